// File: rtl/axi_tdd_frame_sequencer.sv
// TDD frame timing engine: arm on enable, wait for sync, apply start-up delay, run frames.
// Optional internal periodic sync generator is built when AXI_TDD_INT_SYNC_EN is defined.
package axi_tdd_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, WAITING, RUNNING} state_t;
endpackage

module axi_tdd_frame_sequencer
  import axi_tdd_pkg::*;
#(
  parameter int REGISTER_WIDTH    = 32,
  parameter int BURST_COUNT_WIDTH = 32,
  parameter int SYNC_COUNT_WIDTH  = 64
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         tdd_enable,
  input  logic                         tdd_sync_ext_en,
  input  logic                         tdd_sync_ext,
  input  logic                         tdd_sync_soft,
  input  logic                         tdd_sync_int_en,
  input  logic [SYNC_COUNT_WIDTH-1:0]  tdd_sync_period,
  input  logic [REGISTER_WIDTH-1:0]    tdd_startup_delay,
  input  logic [REGISTER_WIDTH-1:0]    tdd_frame_length,
  input  logic [BURST_COUNT_WIDTH-1:0] tdd_burst_count,
  output logic [REGISTER_WIDTH-1:0]    tdd_counter,
  output state_t                       tdd_cstate,
  output logic                         tdd_enable_out,
  output logic                         tdd_endof_frame,
  output logic                         tdd_sync_out,
  output logic [BURST_COUNT_WIDTH-1:0] tdd_frame_index
);

  localparam logic [REGISTER_WIDTH-1:0]    ONE_R = REGISTER_WIDTH'(1);
  localparam logic [BURST_COUNT_WIDTH-1:0] ONE_B = BURST_COUNT_WIDTH'(1);

  logic                         sync_ext_d;
  logic                         int_tick;
  logic                         sync;
  state_t                       state_nxt;
  logic [REGISTER_WIDTH-1:0]    counter_nxt;
  logic [BURST_COUNT_WIDTH-1:0] index_nxt;
  logic [BURST_COUNT_WIDTH-1:0] index_inc;
  logic                         eof_nxt;

`ifdef AXI_TDD_INT_SYNC_EN
  logic [SYNC_COUNT_WIDTH-1:0] sync_cnt;
  logic                        int_run;

  assign int_run  = tdd_enable & tdd_sync_int_en;
  assign int_tick = int_run && (sync_cnt == tdd_sync_period);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      sync_cnt <= '0;
    else if (!int_run || int_tick)
      sync_cnt <= '0;
    else
      sync_cnt <= sync_cnt + SYNC_COUNT_WIDTH'(1);
  end
`else
  logic unused_int_cfg;
  assign unused_int_cfg = tdd_sync_int_en ^ (^tdd_sync_period);
  assign int_tick = 1'b0;
`endif

  assign sync      = (tdd_sync_ext & ~sync_ext_d & tdd_sync_ext_en) | tdd_sync_soft | int_tick;
  assign index_inc = tdd_frame_index + ONE_B;

  // Disable overrides everything; syncs outside ARMED are dropped.
  always_comb begin
    state_nxt   = tdd_cstate;
    counter_nxt = tdd_counter;
    index_nxt   = tdd_frame_index;
    if (!tdd_enable) begin
      state_nxt   = IDLE;
      counter_nxt = '0;
      index_nxt   = '0;
    end else begin
      case (tdd_cstate)
        IDLE: begin
          state_nxt   = ARMED;
          counter_nxt = '0;
          index_nxt   = '0;
        end
        ARMED: begin
          counter_nxt = '0;
          index_nxt   = '0;
          if (sync)
            state_nxt = (tdd_startup_delay == '0) ? RUNNING : WAITING;
        end
        WAITING: begin
          if (tdd_counter == tdd_startup_delay - ONE_R) begin
            state_nxt   = RUNNING;
            counter_nxt = '0;
          end else begin
            counter_nxt = tdd_counter + ONE_R;
          end
        end
        RUNNING: begin
          if (tdd_counter == tdd_frame_length) begin
            counter_nxt = '0;
            index_nxt   = index_inc;
            if ((tdd_burst_count != '0) && (index_inc == tdd_burst_count)) begin
              state_nxt = ARMED;
              index_nxt = '0;
            end
          end else begin
            counter_nxt = tdd_counter + ONE_R;
          end
        end
        default: begin
          state_nxt   = IDLE;
          counter_nxt = '0;
          index_nxt   = '0;
        end
      endcase
    end
  end

  // Registered end-of-frame: flags the cycle whose counter will equal frame_length.
  assign eof_nxt = (state_nxt == RUNNING) && (counter_nxt == tdd_frame_length);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tdd_cstate      <= IDLE;
      tdd_counter     <= '0;
      tdd_frame_index <= '0;
      tdd_endof_frame <= 1'b0;
      tdd_enable_out  <= 1'b0;
      tdd_sync_out    <= 1'b0;
      sync_ext_d      <= 1'b0;
    end else begin
      tdd_cstate      <= state_nxt;
      tdd_counter     <= counter_nxt;
      tdd_frame_index <= index_nxt;
      tdd_endof_frame <= eof_nxt;
      tdd_enable_out  <= tdd_enable;
      tdd_sync_out    <= sync;
      sync_ext_d      <= tdd_sync_ext;
    end
  end

endmodule

// File: doc/axi_tdd_frame_sequencer.md
# axi_tdd_frame_sequencer

Frame timing engine of the TDD controller. It produces the shared frame counter, controller state, frame boundary strobe and synchronized enable that every TDD output channel consumes, so all channels compare against one time base. It arms on enable, waits for a sync event, applies a start-up delay, then runs a programmable number of frames or runs continuously.

## Interface
- REGISTER_WIDTH, 32, width of counter, delay and frame-length values
- BURST_COUNT_WIDTH, 32, width of burst count and frame index
- SYNC_COUNT_WIDTH, 64, width of internal sync period counter
- clk  in  1  single clock for all logic
- resetn  in  1  asynchronous, active-low reset
- tdd_enable  in  1  level; high runs the sequencer, low forces IDLE
- tdd_sync_ext_en  in  1  allow external sync to start a frame sequence
- tdd_sync_ext  in  1  external sync, synchronous to clk, rising-edge detected
- tdd_sync_soft  in  1  one-cycle software sync pulse
- tdd_sync_int_en  in  1  enable internal periodic sync generator
- tdd_sync_period  in  SYNC_COUNT_WIDTH  internal sync period minus 1, in cycles
- tdd_startup_delay  in  REGISTER_WIDTH  cycles between sync and first frame
- tdd_frame_length  in  REGISTER_WIDTH  last counter value of a frame; frame = value+1 cycles
- tdd_burst_count  in  BURST_COUNT_WIDTH  frames per burst; 0 = run forever
- tdd_counter  out  REGISTER_WIDTH  frame/delay counter
- tdd_cstate  out  axi_tdd_pkg::state_t  current state
- tdd_enable_out  out  1  registered tdd_enable, one cycle late
- tdd_endof_frame  out  1  high in the last cycle of each RUNNING frame
- tdd_sync_out  out  1  one-cycle pulse on every accepted sync
- tdd_frame_index  out  BURST_COUNT_WIDTH  frames completed in the current burst

## Operation
- States: IDLE, ARMED, WAITING, RUNNING (axi_tdd_pkg::state_t).
- IDLE: counter 0, frame_index 0. tdd_enable=1 -> ARMED.
- ARMED: counter 0. Sync = (ext rising edge & ext_en) | soft | (internal tick & int_en). On sync: startup_delay=0 -> RUNNING, else -> WAITING.
- WAITING: counter increments from 0. When counter = startup_delay-1: -> RUNNING, counter 0.
- RUNNING: counter increments. When counter = frame_length: endof_frame=1, counter 0, frame_index+1. If burst_count≠0 and frame_index+1 = burst_count: -> ARMED, frame_index 0. Otherwise stay RUNNING.
- tdd_enable=0 in any state: -> IDLE next cycle, counter and frame_index 0. Takes priority over every other event.
- Sync seen outside ARMED is ignored, with no restart and no queueing. tdd_sync_out still pulses for every qualified sync regardless of state.
- frame_length=0: one-cycle frames, endof_frame held high every RUNNING cycle.
- Configuration inputs are sampled live. The register bank guarantees they are stable while tdd_enable=1.
- Counter arithmetic is unsigned with no saturation. Equality compares are at full width.

## Timing
- All outputs are registered.
- Reset values: tdd_counter 0, tdd_cstate IDLE, tdd_enable_out 0, tdd_endof_frame 0, tdd_sync_out 0, tdd_frame_index 0. The ext-sync edge-detect register also resets to 0.
- Enable rises before edge n: cstate=ARMED after edge n.
- Sync sampled before edge m while in ARMED: cstate changes and tdd_sync_out=1 after edge m.
- With delay D>0, RUNNING begins D cycles after WAITING is entered.
- In RUNNING, counter shows 0..frame_length and endof_frame coincides with counter=frame_length.
- Last frame of a burst: ARMED and counter 0 appear one cycle after the endof_frame cycle.
- Sync and disable in the same cycle: disable wins and sync_out is still pulsed.
- Mid-operation resetn assertion: all outputs go to reset values immediately, without waiting for a clock edge.

## Configuration
- AXI_TDD_INT_SYNC_EN defined: the internal sync generator is built. It counts 0..tdd_sync_period while tdd_enable & tdd_sync_int_en, ticks at terminal count, and resets to 0 when either input is low.
- AXI_TDD_INT_SYNC_EN undefined: the generator is removed. tdd_sync_int_en and tdd_sync_period are ignored, and only ext/soft syncs start sequences.

## Test plan
- Reset, enable=1, soft sync, delay=0, frame_length=4, burst=2 -> counter 0..4 twice; endof_frame at both counter=4 cycles; then ARMED, frame_index back to 0.
- delay=3, ext_en=1, hold ext high 5 cycles -> single sync accepted; WAITING counter 0,1,2; RUNNING on the 4th cycle after sync.
- burst=0, frame_length=0, soft sync -> endof_frame continuously high; frame_index increments every cycle and wraps at 2^BURST_COUNT_WIDTH.
- RUNNING mid-frame with counter=2 and enable dropped -> IDLE next cycle, counter 0; a soft sync arriving in RUNNING is ignored except for tdd_sync_out.
- With AXI_TDD_INT_SYNC_EN, int_en=1, period=9 -> sync_out every 10 cycles and burst restarts on each tick while ARMED. Without the macro -> no sync_out and the sequencer stays ARMED.
- resetn pulsed low mid-WAITING -> outputs zero/IDLE immediately; sequence restarts from IDLE after release.
